// File: rtl/keccak_pkg.sv
// keccak_pkg: shared constants, FSM state encoding and byte-lane helper for
// the keccak byte packer and its output slot.
package keccak_pkg;

    localparam int WORD_W         = 64;
    localparam int BYTES_PER_WORD = 8;

    // Packer states: ACCUM gathers bytes, TAIL owes an empty final word,
    // FINAL waits for the final word to drain, DONE is terminal until reset.
    typedef enum logic [1:0] {
        ACCUM = 2'd0,
        TAIL  = 2'd1,
        FINAL = 2'd2,
        DONE  = 2'd3
    } state_e;

    // Top bit of the byte lane that holds byte number cnt of a word
    // (first byte of a word lands in [63:56]).
    function automatic logic [5:0] lane(input logic [2:0] cnt);
        lane = 6'd63 - {cnt, 3'b000};
    endfunction

endpackage

// File: rtl/keccak_word_slot.sv
// keccak_word_slot: one-entry output register between the packer and the
// keccak core. Holds {word, last, byte_num, valid}; a word drains in any cycle
// where the slot is valid and the core is not full.
//
// Ports:
//   clk, reset          clock, asynchronous active-high reset
//   push_i              load a new entry (only issued when free_o is high)
//   push_word_i         word to load
//   push_last_i         entry is the final word of the message
//   push_byte_num_i     valid bytes in the final word
//   buffer_full_i       core cannot accept a word this cycle
//   free_o              slot empty or draining this cycle
//   word_o              held word (core input bus)
//   in_ready_o          transfer to core this cycle
//   is_last_o           final-word marker, high only on the transfer cycle
//   byte_num_o          final-word byte count, nonzero only with is_last_o
module keccak_word_slot
    import keccak_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              push_i,
    input  logic [WORD_W-1:0] push_word_i,
    input  logic              push_last_i,
    input  logic [2:0]        push_byte_num_i,
    input  logic              buffer_full_i,
    output logic              free_o,
    output logic [WORD_W-1:0] word_o,
    output logic              in_ready_o,
    output logic              is_last_o,
    output logic [2:0]        byte_num_o
);

    logic              valid_q;
    logic [WORD_W-1:0] word_q;
    logic              last_q;
    logic [2:0]        byte_num_q;
    logic              drain_s;

    // Drain decode and gated core-side outputs; the core latches is_last every
    // cycle, so last/byte_num must be zero outside a transfer.
    always_comb begin
        drain_s    = valid_q & ~buffer_full_i;
        free_o     = ~valid_q | drain_s;
        in_ready_o = drain_s;
        word_o     = word_q;
        if (drain_s && last_q) begin
            is_last_o  = 1'b1;
            byte_num_o = byte_num_q;
        end else begin
            is_last_o  = 1'b0;
            byte_num_o = 3'd0;
        end
    end

    // Slot register: load on push, empty on drain, otherwise hold.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            valid_q    <= 1'b0;
            word_q     <= '0;
            last_q     <= 1'b0;
            byte_num_q <= 3'd0;
        end else if (push_i) begin
            valid_q    <= 1'b1;
            word_q     <= push_word_i;
            last_q     <= push_last_i;
            byte_num_q <= push_byte_num_i;
        end else if (drain_s) begin
            valid_q    <= 1'b0;
        end else begin
            valid_q    <= valid_q;
        end
    end

endmodule

// File: rtl/keccak_byte_packer.sv
// keccak_byte_packer: packs a valid/ready/last byte stream big-endian into
// 64-bit words for the keccak core, terminating every message with exactly one
// is_last transfer (a partial word, or an empty word when the message ends on
// a word boundary).
//
// Ports:
//   clk, reset        clock, asynchronous active-high reset
//   s_byte/s_valid    input byte stream
//   s_last            with s_valid: byte ends the message
//   s_flush           end the message without a byte
//   s_ready           byte/flush accepted at the clock edge when high
//   k_in              word to core, first byte in [63:56]
//   k_in_ready        one-cycle word transfer to core
//   k_is_last         final word marker (transfer cycle only)
//   k_byte_num        valid bytes in the final word
//   k_buffer_full     core backpressure
//   done              final word delivered, sticky until reset
//   msg_len           accepted byte count (saturating)
//
// Build option: define PACKER_LEN_COUNT_EN to add the msg_len counter/port.
module keccak_byte_packer
    import keccak_pkg::*;
#(
    parameter int LEN_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [7:0]        s_byte,
    input  logic              s_valid,
    input  logic              s_last,
    input  logic              s_flush,
    output logic              s_ready,
    output logic [WORD_W-1:0] k_in,
    output logic              k_in_ready,
    output logic              k_is_last,
    output logic [2:0]        k_byte_num,
    input  logic              k_buffer_full,
`ifdef PACKER_LEN_COUNT_EN
    output logic [LEN_W-1:0]  msg_len,
`endif
    output logic              done
);

    state_e            state_q;
    logic [WORD_W-1:0] acc_q;
    logic [2:0]        cnt_q;
    logic              done_q;

    logic              slot_free_s;
    logic              s_ready_s;
    logic [WORD_W-1:0] acc_ins_s;
    logic              accept_byte_s;
    logic              accept_flush_s;
    logic              byte_end_s;
    logic              word_full_s;
    logic              push_s;
    logic [WORD_W-1:0] push_word_s;
    logic              push_last_s;
    logic [2:0]        push_byte_num_s;

    // Handshake decode and the word/marker to push into the output slot.
    always_comb begin
        // Reset also masks s_ready so every output reads 0 while reset is held.
        s_ready_s      = ~reset & (state_q == ACCUM) & slot_free_s;
        acc_ins_s      = acc_q;
        acc_ins_s[lane(cnt_q) -: 8] = s_byte;
        accept_byte_s  = s_ready_s & s_valid;
        accept_flush_s = s_ready_s & ~s_valid & s_flush;
        // A flush arriving with a byte marks that byte as the last one.
        byte_end_s     = s_last | s_flush;
        word_full_s    = (cnt_q == 3'(BYTES_PER_WORD - 1));

        push_s          = 1'b0;
        push_word_s     = '0;
        push_last_s     = 1'b0;
        push_byte_num_s = 3'd0;
        case (state_q)
            ACCUM: begin
                if (accept_byte_s && (word_full_s || byte_end_s)) begin
                    push_s      = 1'b1;
                    push_word_s = acc_ins_s;
                    // An end byte that fills the word cannot carry is_last:
                    // byte_num cannot express 8, so an empty word follows.
                    if (byte_end_s && !word_full_s) begin
                        push_last_s     = 1'b1;
                        push_byte_num_s = cnt_q + 3'd1;
                    end else begin
                        push_last_s     = 1'b0;
                        push_byte_num_s = 3'd0;
                    end
                end else if (accept_flush_s) begin
                    push_s          = 1'b1;
                    push_word_s     = acc_q;
                    push_last_s     = 1'b1;
                    push_byte_num_s = cnt_q;
                end else begin
                    push_s = 1'b0;
                end
            end
            TAIL: begin
                if (slot_free_s) begin
                    push_s      = 1'b1;
                    push_last_s = 1'b1;
                end else begin
                    push_s = 1'b0;
                end
            end
            default: begin
                push_s = 1'b0;
            end
        endcase
    end

    // Packer FSM with accumulator, byte count and sticky done flag.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ACCUM;
            acc_q   <= '0;
            cnt_q   <= 3'd0;
            done_q  <= 1'b0;
        end else begin
            case (state_q)
                ACCUM: begin
                    if (accept_byte_s) begin
                        if (word_full_s || byte_end_s) begin
                            acc_q <= '0;
                            cnt_q <= 3'd0;
                        end else begin
                            acc_q <= acc_ins_s;
                            cnt_q <= cnt_q + 3'd1;
                        end
                        if (byte_end_s) begin
                            state_q <= word_full_s ? TAIL : FINAL;
                        end
                    end else if (accept_flush_s) begin
                        acc_q   <= '0;
                        cnt_q   <= 3'd0;
                        state_q <= FINAL;
                    end
                end
                TAIL: begin
                    if (slot_free_s) begin
                        state_q <= FINAL;
                    end
                end
                FINAL: begin
                    // Only the final word can be in the slot here.
                    if (k_is_last) begin
                        done_q  <= 1'b1;
                        state_q <= DONE;
                    end
                end
                default: begin
                    state_q <= DONE;
                end
            endcase
        end
    end

    keccak_word_slot u_slot (
        .clk             (clk),
        .reset           (reset),
        .push_i          (push_s),
        .push_word_i     (push_word_s),
        .push_last_i     (push_last_s),
        .push_byte_num_i (push_byte_num_s),
        .buffer_full_i   (k_buffer_full),
        .free_o          (slot_free_s),
        .word_o          (k_in),
        .in_ready_o      (k_in_ready),
        .is_last_o       (k_is_last),
        .byte_num_o      (k_byte_num)
    );

    assign s_ready = s_ready_s;
    assign done    = done_q;

`ifdef PACKER_LEN_COUNT_EN
    logic [LEN_W-1:0] len_q;

    // Saturating count of accepted bytes; no bytes are accepted after the end.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            len_q <= '0;
        end else if (accept_byte_s && (len_q != {LEN_W{1'b1}})) begin
            len_q <= len_q + LEN_W'(1);
        end
    end

    assign msg_len = len_q;
`else
    logic unused_len_w_s;
    assign unused_len_w_s = (LEN_W > 0);
`endif

endmodule

// File: tb/tb_keccak_byte_packer.sv
module tb_keccak_byte_packer;

    logic        clk;
    logic        reset;
    logic [7:0]  s_byte;
    logic        s_valid;
    logic        s_last;
    logic        s_flush;
    logic        s_ready;
    logic [63:0] k_in;
    logic        k_in_ready;
    logic        k_is_last;
    logic [2:0]  k_byte_num;
    logic        k_buffer_full;
    logic        done;
`ifdef PACKER_LEN_COUNT_EN
    logic [31:0] msg_len;
`endif

    int checks = 0;
    int errors = 0;
    int last_viol = 0;

    logic [63:0] cap_word[$];
    logic        cap_last[$];
    logic [2:0]  cap_bn[$];

    keccak_byte_packer #(.LEN_W(32)) dut (
        .clk           (clk),
        .reset         (reset),
        .s_byte        (s_byte),
        .s_valid       (s_valid),
        .s_last        (s_last),
        .s_flush       (s_flush),
        .s_ready       (s_ready),
        .k_in          (k_in),
        .k_in_ready    (k_in_ready),
        .k_is_last     (k_is_last),
        .k_byte_num    (k_byte_num),
        .k_buffer_full (k_buffer_full),
`ifdef PACKER_LEN_COUNT_EN
        .msg_len       (msg_len),
`endif
        .done          (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Capture every transfer and flag any last/byte_num outside a final transfer.
    always @(negedge clk) begin
        if (!reset) begin
            if (k_in_ready === 1'b1) begin
                cap_word.push_back(k_in);
                cap_last.push_back(k_is_last);
                cap_bn.push_back(k_byte_num);
            end
            if (k_is_last === 1'b1 && k_in_ready !== 1'b1) last_viol++;
            if (k_byte_num !== 3'd0 && k_is_last !== 1'b1) last_viol++;
        end
    end

    task automatic wait_cycles(input int n);
        for (int i = 0; i < n; i++) @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [7:0] b, input logic v, input logic l, input logic f);
        int n = 0;
        s_byte = b; s_valid = v; s_last = l; s_flush = f;
        @(negedge clk);
        while (s_ready !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (s_ready !== 1'b1) begin
            errors++;
            $display("FAIL send_timeout byte=%h s_ready=%b required 1", b, s_ready);
        end
        @(posedge clk);
        #1;
        s_valid = 1'b0; s_last = 1'b0; s_flush = 1'b0; s_byte = 8'h00;
    endtask

    task automatic wait_transfers(input int n);
        int k = 0;
        while (cap_word.size() < n && k < 40) begin
            @(negedge clk);
            k++;
        end
        checks++;
        if (cap_word.size() < n) begin
            errors++;
            $display("FAIL transfer_timeout got=%0d required=%0d", cap_word.size(), n);
        end
        wait_cycles(3);
    endtask

    task automatic check_word(input int idx, input logic [63:0] w, input logic l, input logic [2:0] bn);
        checks++;
        if (cap_word.size() <= idx) begin
            errors++;
            $display("FAIL word%0d_missing size=%0d", idx, cap_word.size());
        end else if (cap_word[idx] !== w || cap_last[idx] !== l || cap_bn[idx] !== bn) begin
            errors++;
            $display("FAIL word%0d got=%h/%b/%0d required=%h/%b/%0d", idx,
                     cap_word[idx], cap_last[idx], cap_bn[idx], w, l, bn);
        end
    endtask

    task automatic check_common(input string name, input int nwords);
        checks++;
        if (cap_word.size() !== nwords) begin
            errors++;
            $display("FAIL %s_count got=%0d required=%0d", name, cap_word.size(), nwords);
        end
        checks++;
        if (last_viol !== 0) begin
            errors++;
            $display("FAIL %s_last_gating got=%0d required=0", name, last_viol);
        end
        checks++;
        if (done !== 1'b1 || s_ready !== 1'b0) begin
            errors++;
            $display("FAIL %s_done got done=%b s_ready=%b required 1/0", name, done, s_ready);
        end
    endtask

    task automatic test_reset;
        @(posedge clk); #1;
        reset = 1'b1;
        s_valid = 1'b0; s_last = 1'b0; s_flush = 1'b0; s_byte = 8'h00; k_buffer_full = 1'b0;
        #2;
        checks++;
        if (s_ready !== 1'b0 || k_in_ready !== 1'b0 || k_in !== 64'h0 || k_is_last !== 1'b0 ||
            k_byte_num !== 3'd0 || done !== 1'b0) begin
            errors++;
            $display("FAIL reset_outputs got=%b%b%h%b%0d%b required all zero",
                     s_ready, k_in_ready, k_in, k_is_last, k_byte_num, done);
        end
`ifdef PACKER_LEN_COUNT_EN
        checks++;
        if (msg_len !== 32'd0) begin
            errors++;
            $display("FAIL reset_msg_len got=%0d required=0", msg_len);
        end
`endif
        wait_cycles(2);
        reset = 1'b0;
        cap_word.delete(); cap_last.delete(); cap_bn.delete();
        last_viol = 0;
        #1;
        checks++;
        if (s_ready !== 1'b1) begin
            errors++;
            $display("FAIL post_reset_ready got=%b required=1", s_ready);
        end
    endtask

    task automatic test_short_msg;
        send(8'h61, 1'b1, 1'b0, 1'b0);
        send(8'h62, 1'b1, 1'b0, 1'b0);
        send(8'h63, 1'b1, 1'b1, 1'b0);
        wait_transfers(1);
        check_word(0, 64'h6162630000000000, 1'b1, 3'd3);
        check_common("short", 1);
`ifdef PACKER_LEN_COUNT_EN
        checks++;
        if (msg_len !== 32'd3) begin
            errors++;
            $display("FAIL short_msg_len got=%0d required=3", msg_len);
        end
`endif
        // Bytes after the end must be ignored.
        s_byte = 8'h64; s_valid = 1'b1; s_flush = 1'b1;
        wait_cycles(4);
        s_valid = 1'b0; s_flush = 1'b0;
        wait_cycles(2);
        check_common("after_done", 1);
    endtask

    task automatic test_aligned;
        for (int i = 0; i < 8; i++) send(8'(i), 1'b1, (i == 7), 1'b0);
        wait_transfers(2);
        check_word(0, 64'h0001020304050607, 1'b0, 3'd0);
        check_word(1, 64'h0000000000000000, 1'b1, 3'd0);
        check_common("aligned", 2);
    endtask

    task automatic test_flush_empty;
        send(8'h00, 1'b0, 1'b0, 1'b1);
        wait_transfers(1);
        check_word(0, 64'h0, 1'b1, 3'd0);
        check_common("empty", 1);
    endtask

    task automatic test_backpressure;
        fork
            begin
                for (int i = 1; i <= 20; i++) send(8'(i), 1'b1, (i == 20), 1'b0);
            end
            begin
                int n = 0;
                while (cap_word.size() < 1 && n < 60) begin
                    @(negedge clk);
                    n++;
                end
                @(posedge clk); #1;
                k_buffer_full = 1'b1;
                n = 0;
                @(negedge clk);
                while (s_ready === 1'b1 && n < 40) begin
                    @(negedge clk);
                    n++;
                end
                checks++;
                if (s_ready !== 1'b0) begin
                    errors++;
                    $display("FAIL bp_stall_timeout s_ready=%b required 0", s_ready);
                end
                for (int c = 0; c < 5; c++) begin
                    checks++;
                    if (k_in_ready !== 1'b0 || s_ready !== 1'b0) begin
                        errors++;
                        $display("FAIL bp_hold cyc=%0d got k_in_ready=%b s_ready=%b required 0/0",
                                 c, k_in_ready, s_ready);
                    end
                    @(negedge clk);
                end
                @(posedge clk); #1;
                k_buffer_full = 1'b0;
            end
        join
        wait_transfers(3);
        check_word(0, 64'h0102030405060708, 1'b0, 3'd0);
        check_word(1, 64'h090A0B0C0D0E0F10, 1'b0, 3'd0);
        check_word(2, 64'h1112131400000000, 1'b1, 3'd4);
        check_common("bp", 3);
    endtask

    task automatic test_reset_mid;
        for (int i = 0; i < 5; i++) send(8'hF0 + 8'(i), 1'b1, 1'b0, 1'b0);
        #3;
        reset = 1'b1;
        #1;
        checks++;
        if (s_ready !== 1'b0 || k_in_ready !== 1'b0 || k_in !== 64'h0 || k_is_last !== 1'b0 ||
            k_byte_num !== 3'd0 || done !== 1'b0) begin
            errors++;
            $display("FAIL async_reset got=%b%b%h%b%0d%b required all zero",
                     s_ready, k_in_ready, k_in, k_is_last, k_byte_num, done);
        end
        wait_cycles(2);
        reset = 1'b0;
        cap_word.delete(); cap_last.delete(); cap_bn.delete();
        last_viol = 0;
        send(8'hAA, 1'b1, 1'b0, 1'b0);
        send(8'hBB, 1'b1, 1'b1, 1'b0);
        wait_transfers(1);
        check_word(0, 64'hAABB000000000000, 1'b1, 3'd2);
        check_common("reset_mid", 1);
`ifdef PACKER_LEN_COUNT_EN
        checks++;
        if (msg_len !== 32'd2) begin
            errors++;
            $display("FAIL reset_mid_msg_len got=%0d required=2", msg_len);
        end
`endif
    endtask

    initial begin
        reset = 1'b1;
        s_byte = 8'h00; s_valid = 1'b0; s_last = 1'b0; s_flush = 1'b0;
        k_buffer_full = 1'b0;
        test_reset();
        test_short_msg();
        test_reset();
        test_aligned();
        test_reset();
        test_flush_empty();
        test_reset();
        test_backpressure();
        test_reset();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/keccak_byte_packer.md
Name: keccak_byte_packer

Overview:
- Upstream feeder for the keccak core.
- Accepts a byte stream with valid/ready/last handshake and packs bytes big-endian into 64-bit words.
- Drives the core's in / in_ready / is_last / byte_num interface and honours buffer_full backpressure.
- Guarantees the core's termination rules: a final partial word or an empty final word, and is_last asserted only on the single final transfer.

Parameters:
- LEN_W, 32, width of the optional message-length counter (bytes).

Ports:
- clk  input  1  clock, all state on rising edge
- reset  input  1  asynchronous, active-high; clears all state
- s_byte  input  8  message byte
- s_valid  input  1  s_byte valid
- s_last  input  1  with s_valid: this byte ends the message
- s_flush  input  1  end message with no byte this cycle (supports empty and byte-aligned ends)
- s_ready  output  1  byte/flush accepted when high at clock edge
- k_in  output  64  word to core; first byte of word in [63:56]
- k_in_ready  output  1  word valid to core (one-cycle transfer)
- k_is_last  output  1  final word marker
- k_byte_num  output  3  valid bytes in final word (0..7)
- k_buffer_full  input  1  core cannot accept a word
- done  output  1  final word delivered; sticky until reset
- msg_len  output  LEN_W  bytes accepted (only with PACKER_LEN_COUNT_EN)

Behaviour:
- Reset values (asynchronous): all outputs 0, acc=0, cnt=0, out slot empty, state=ACCUM.
- Datapath: accumulator acc[63:0] plus cnt[2:0] = bytes held (0..7). Single-entry output slot holds {word, last, byte_num, valid}.
- drain = slot_valid & ~k_buffer_full.
- k_in_ready = drain (combinational). k_in shows the slot word.
- k_is_last = drain & slot_last; k_byte_num = drain & slot_last ? slot_byte_num : 0. Both are forced to 0 outside transfer cycles, because the core latches is_last unconditionally.
- Push condition: slot is free (~slot_valid | drain).
- s_ready = (state==ACCUM) & push condition. This is combinational from k_buffer_full.
- States and transitions:
  - ACCUM, byte accepted, cnt<7, no s_last: byte is written to lane cnt (bits [63-8*cnt -: 8]); cnt++.
  - ACCUM, byte accepted, cnt==7, no s_last: full word is pushed with last=0; acc cleared; cnt=0.
  - ACCUM, byte accepted with s_last, cnt<7: word with cnt+1 bytes is pushed, last=1, byte_num=cnt+1; unused low bytes are zero; go to FINAL.
  - ACCUM, byte accepted with s_last, cnt==7: full word is pushed with last=0; go to TAIL.
  - ACCUM, s_flush accepted without s_valid: word is pushed, last=1, byte_num=cnt. With cnt==0 this is an empty final word (byte_num 0, k_in=0). Go to FINAL.
  - s_valid and s_flush in the same cycle: treated as s_valid with s_last=1.
  - TAIL: s_ready=0. When the slot is free, push an empty final word (k_in=0, last=1, byte_num=0); go to FINAL.
  - FINAL: s_ready=0. When the final word drains, done<=1 and go to DONE.
  - DONE: s_ready=0, k_in_ready=0. All input is ignored. Only reset exits DONE.
- Latency: the word reaches k_in the cycle after its completing byte is accepted. A transfer completes in that same cycle if k_buffer_full=0.
- Backpressure: the slot holds steady while k_buffer_full=1. s_ready falls and the accumulator holds; no byte is lost or duplicated.
- Reset mid-message: partial word discarded, return to ACCUM with cnt=0. The core must be reset together with this block.

Optional Feature:
- Macro: PACKER_LEN_COUNT_EN.
- Defined: msg_len counts accepted bytes, including the s_last byte. It saturates at all-ones, is cleared by reset, and freezes in DONE.
- Undefined: msg_len port absent, no counter logic.

Decomposition:
- keccak_pkg holds:
  - WORD_W=64, BYTES_PER_WORD=8.
  - State enum: ACCUM, TAIL, FINAL, DONE.
  - Helper for byte lane index: lane(cnt) = 63-8*cnt.
- Sub-module keccak_word_slot: the one-entry output register with push/drain and the gated last/byte_num outputs.
- The packer top holds the FSM, accumulator and counter.

Test Plan:
- 3 bytes 0x61,0x62,0x63, last on 0x63, buffer_full=0 -> one transfer: k_in=0x6162630000000000, k_is_last=1, k_byte_num=3; done=1 next cycle; later bytes ignored.
- 8 bytes 0x00..0x07, last on 0x07 -> transfer 1: k_in=0x0001020304050607, is_last=0. Transfer 2: k_in=0, is_last=1, byte_num=0. done=1.
- s_flush only after reset -> single transfer k_in=0, is_last=1, byte_num=0 (empty message).
- 20 bytes 0x01..0x14, k_buffer_full held high 5 cycles after word 1 -> k_in_ready=0 and s_ready=0 while full. Words are delivered intact in order: 0x0102..08, 0x090A..10, then 0x11121314_00000000 with byte_num=4.
- Check k_is_last across every cycle of all tests -> never high except the single final transfer cycle.
- Reset asserted asynchronously mid-word (cnt=5) -> all outputs 0 immediately. A new 2-byte message then yields byte_num=2 with no stale bytes. With PACKER_LEN_COUNT_EN, msg_len=2.
